// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: FETCH -> EXEC -> FETCH loop with redirect and halt-on-fault.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer that fetches r_pc+4 during EXEC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_fetch_addr,
    output logic        o_fetch_ready,
    input  logic [31:0] i_fetch_data,
    input  logic        i_fetch_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_finished,
    input  logic        i_pc_change,
    input  logic [31:0] i_new_pc,
    input  logic        i_invalid_inst,
    output logic        o_halted,
    output logic [1:0]  o_fault
);

    // RV32 canonical NOP (addi x0, x0, 0), shown whenever no instruction is live.
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] FAULT_NONE      = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL   = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN  = 2'd2;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] pc_plus4;
    logic        xfer;

`ifdef FETCH_PREFETCH_EN
    logic        pf_valid_q, pf_valid_d;
    logic [31:0] pf_data_q, pf_data_d;
`endif

    assign pc_plus4 = pc_q + 32'd4;
    assign o_pc     = pc_q;
    assign o_fault  = fault_q;
    assign o_halted = (state_q == HALT);
    assign xfer     = o_fetch_ready & i_fetch_valid;

    always_comb begin
        o_fetch_ready = 1'b0;
        o_fetch_addr  = pc_q;
        o_inst        = NOP;
        case (state_q)
            FETCH: o_fetch_ready = 1'b1;
            EXEC: begin
                o_inst = inst_q;
`ifdef FETCH_PREFETCH_EN
                o_fetch_ready = ~pf_valid_q;
                o_fetch_addr  = pc_plus4;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
`ifdef FETCH_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_data_d  = pf_data_q;
`endif
        case (state_q)
            FETCH: begin
                if (xfer) begin
                    inst_d  = i_fetch_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (i_invalid_inst) begin
                    state_d = HALT;
                    fault_d = FAULT_ILLEGAL;
`ifdef FETCH_PREFETCH_EN
                    pf_valid_d = 1'b0;
`endif
                end else if (i_finished && i_pc_change) begin
                    if (i_new_pc[1:0] == 2'b00) begin
                        pc_d    = i_new_pc;
                        state_d = FETCH;
                    end else begin
                        state_d = HALT;
                        fault_d = FAULT_MISALIGN;
                    end
`ifdef FETCH_PREFETCH_EN
                    pf_valid_d = 1'b0;
`endif
                end else if (i_finished) begin
                    pc_d = pc_plus4;
`ifdef FETCH_PREFETCH_EN
                    // Buffered or same-cycle word becomes the next instruction with no bubble.
                    if (pf_valid_q) begin
                        inst_d     = pf_data_q;
                        pf_valid_d = 1'b0;
                    end else if (xfer) begin
                        inst_d = i_fetch_data;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    state_d = FETCH;
`endif
                end else begin
`ifdef FETCH_PREFETCH_EN
                    if (xfer) begin
                        pf_valid_d = 1'b1;
                        pf_data_d  = i_fetch_data;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            inst_q  <= NOP;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

`ifdef FETCH_PREFETCH_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pf_valid_q <= 1'b0;
            pf_data_q  <= NOP;
        end else begin
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
        end
    end
`endif

endmodule
